uart_rx_status: RTL and testbench
=================================

# uart_rx_status

UART receiver that deserialises the asynchronous `rx_i` line into bytes and drives a 2-bit status vector. It sits directly upstream of the UART interrupt PIO: `status_o[1:0]` connects to that PIO's `in_port`. A rising edge on `status_o[0]` (byte ready) or `status_o[1]` (error) is captured there and raises the Nios II IRQ. Software reads the byte through `rx_data_o` and releases it with `rd_ack_i`.

## Interface
- `CLK_HZ`, default 50000000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `OVERSAMPLE`, default 16: baud ticks per bit; must be even and ≥ 8.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `rx_i`  in  1  serial line; asynchronous; idle high.
- `rd_ack_i`  in  1  one-cycle pulse; software has consumed the byte.
- `rx_data_o`  out  8  last accepted byte.
- `status_o`  out  2  bit0 = byte ready (level); bit1 = error, sticky (framing, overrun, parity).
- `busy_o`  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- `rx_i` passes through a 2-flop synchroniser with reset value 1. All logic below uses the synchronised value `rx_s`.
- Baud tick:
  - DIV = CLK_HZ / (BAUD·OVERSAMPLE), integer division. Defaults give DIV = 27.
  - The tick counter counts 0..DIV-1 and emits a one-cycle `tick` on DIV-1.
  - The counter is free-running in IDLE and restarts from 0 on start-edge detection.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP. All FSM actions occur on cycles with `tick`. Sample counter `sc` spans 0..OVERSAMPLE-1.
  - IDLE: on `rx_s` = 0, go to START with `sc` = 0.
  - START: at `sc` = OVERSAMPLE/2-1 (mid-bit), sample. If `rx_s` = 1 it is a glitch: return to IDLE with no status change. Otherwise go to DATA, `sc` = 0, bit index 0.
  - DATA: at `sc` = OVERSAMPLE-1, shift `rx_s` into the MSB of the shift register (LSB-first line order). After 8 bits go to PARITY or STOP.
  - PARITY: at `sc` = OVERSAMPLE-1, sample the parity bit.
  - STOP: at `sc` = OVERSAMPLE-1, sample the stop bit, then go to IDLE in the same cycle. Back-to-back frames are supported.
- Frame completion, evaluated in the cycle after the stop sample:
  - Stop bit = 0: set error; do not load data; leave ready unchanged.
  - Stop bit = 1 and ready = 0: load `rx_data_o` and set ready.
  - Stop bit = 1 and ready = 1: overrun. Set error; keep the old byte; drop the new byte.
- `rd_ack_i` clears ready and error in the following cycle.
- Ack in the same cycle as completion: the ack is applied first, so the new byte loads, ready stays 1 and no overrun is flagged. A framing error completing in that cycle still sets error.
- `rd_ack_i` while ready = 0 has no effect.
- Mid-operation reset: all state returns to reset values immediately; any partial frame is discarded.

## Timing
- Reset values: `rx_data_o` = 8'h00, `status_o` = 2'b00, `busy_o` = 0, FSM = IDLE, sync flops = 1.
- Start-edge detect: 2–3 clk after `rx_i` falls (synchroniser delay plus tick alignment).
- `status_o[0]` rises 1 clk after the stop-bit sample tick, about 9.5 bit times (10.5 with parity) after the start edge.
- `status_o` is registered, so the downstream PIO sees a clean rising edge.
- `rd_ack_i` → `status_o` = 00 at the next clk edge.

## Configuration
- `UART_RX_PARITY_EN`
  - Defined: a PARITY state is inserted. Even parity is checked over data plus the parity bit; a mismatch sets error and the byte is still loaded if ready = 0.
  - Undefined: no PARITY state; frame is 8N1.

## Structure
- Package `uart_pkg`:
  - FSM state enum `uart_rx_state_t`
  - `UART_DATA_BITS` = 8
  - status bit indices `UART_ST_READY` = 0 and `UART_ST_ERR` = 1
- Sub-module `uart_baud_tick`: parameterised divider with `restart` input and `tick` output, reusable by a future transmitter.

## Test plan
- Send 8'hA5 at 115200 baud → `rx_data_o` = 8'hA5 and `status_o` = 01 about 9.5 bit times after the start edge; pulse `rd_ack_i` → `status_o` = 00 on the next clk.
- Send 8'h3C then 8'hC3 back-to-back without ack → `rx_data_o` stays 8'h3C and `status_o` = 11 (overrun); ack → 00.
- 8'h55 frame with stop bit forced to 0 → `status_o` = 10 and `rx_data_o` unchanged.
- 1-bit-time/4 low glitch on `rx_i` → FSM returns to IDLE; `status_o` stays 00 and `busy_o` pulses only.
- Ack pulse in the exact completion cycle of a second byte 8'h81 → `rx_data_o` = 8'h81, `status_o` = 01, no error.
- With `UART_RX_PARITY_EN`: send 8'h07 with parity bit 0 → `status_o` = 11 and `rx_data_o` = 8'h07. Assert reset mid-frame → all outputs return to 0 and the next frame is received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and status bit positions.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_rx_state_t;

    localparam int UART_DATA_BITS = 8;

    localparam int UART_ST_READY = 0;
    localparam int UART_ST_ERR   = 1;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling baud divider: one-cycle tick every DIV clocks, counter restartable from 0.
// Latency: tick is decoded from the counter register, DIV cycles after restart.
// Backpressure: none; free-running.
module uart_baud_tick #(
    parameter int unsigned DIV = 27
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_status.sv
// UART receiver feeding a 2-bit IRQ status vector (ready, sticky error); UART_RX_PARITY_EN adds even parity.
// Latency: status rises 1 clk after the stop-bit sample; rd_ack clears status on the next edge.
// Backpressure: none; a byte completing while ready is set is dropped and flagged as overrun.
module uart_rx_status
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_i,
    input  logic       rd_ack_i,
    output logic [7:0] rx_data_o,
    output logic [1:0] status_o,
    output logic       busy_o
);

    localparam int unsigned DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam int BIW = $clog2(UART_DATA_BITS);
    localparam logic [SCW-1:0] SC_MID  = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
    localparam logic [BIW-1:0] BI_LAST = BIW'(UART_DATA_BITS - 1);

    logic                      rx_meta;
    logic                      rx_s;
    logic                      restart;
    logic                      tick;
    uart_rx_state_t            state;
    logic [SCW-1:0]            sc;
    logic [BIW-1:0]            bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      stop_bit;
    logic                      done;
    logic                      par_err;
    logic                      ready;
    logic                      ack_eff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    // Realign the divider to the falling start edge so samples land mid-bit.
    assign restart = (state == ST_IDLE) && !rx_s;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .restart(restart),
        .tick   (tick)
    );

`ifndef UART_RX_PARITY_EN
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            sc       <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            stop_bit <= 1'b1;
            done     <= 1'b0;
            busy_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state  <= ST_START;
                        sc     <= '0;
                        busy_o <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (sc == SC_MID) begin
                            if (rx_s) begin
                                state  <= ST_IDLE;
                                busy_o <= 1'b0;
                            end else begin
                                state   <= ST_DATA;
                                sc      <= '0;
                                bit_idx <= '0;
                            end
                        end else begin
                            sc <= sc + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (sc == SC_LAST) begin
                            shreg   <= {rx_s, shreg[UART_DATA_BITS-1:1]};
                            sc      <= '0;
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == BI_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= ST_PARITY;
`else
                                state <= ST_STOP;
`endif
                            end
                        end else begin
                            sc <= sc + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        if (sc == SC_LAST) begin
                            par_err <= ^{shreg, rx_s};
                            sc      <= '0;
                            state   <= ST_STOP;
                        end else begin
                            sc <= sc + 1'b1;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        if (sc == SC_LAST) begin
                            stop_bit <= rx_s;
                            done     <= 1'b1;
                            sc       <= '0;
                            state    <= ST_IDLE;
                            busy_o   <= 1'b0;
                        end else begin
                            sc <= sc + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    assign ready   = status_o[UART_ST_READY];
    assign ack_eff = rd_ack_i && ready;

    // An ack landing with a completion is applied first, so the new byte is not an overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data_o <= '0;
            status_o  <= '0;
        end else begin
            if (ack_eff) begin
                status_o <= 2'b00;
            end
            if (done) begin
                if (!stop_bit) begin
                    status_o[UART_ST_ERR] <= 1'b1;
                end else if (!ready || ack_eff) begin
                    rx_data_o               <= shreg;
                    status_o[UART_ST_READY] <= 1'b1;
                    if (par_err) begin
                        status_o[UART_ST_ERR] <= 1'b1;
                    end
                end else begin
                    status_o[UART_ST_ERR] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_status.sv
// Randomised bench for uart_rx_status: line-level frame driver, byte/status reference model, scoreboard monitor.
module tb_uart_rx_status;

    localparam int unsigned CLK_HZ = 7372800;
    localparam int unsigned BAUD   = 115200;
    localparam int unsigned OS     = 16;
    localparam int T = int'(CLK_HZ / (BAUD * OS)) * int'(OS);

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_i = 1'b1;
    logic       rd_ack_i = 1'b0;
    logic [7:0] rx_data_o;
    logic [1:0] status_o;
    logic       busy_o;

    uart_rx_status #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OS)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_i     (rx_i),
        .rd_ack_i (rd_ack_i),
        .rx_data_o(rx_data_o),
        .status_o (status_o),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] status;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] m_data;
    logic       m_ready;
    logic       m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic void model_reset();
        m_data  = 8'h00;
        m_ready = 1'b0;
        m_err   = 1'b0;
    endfunction

    function automatic void model_push();
        exp_q.push_back({m_data, m_err, m_ready});
    endfunction

    function automatic void model_frame(input logic [7:0] d, input logic stop_ok,
                                        input logic par_ok, input logic ack);
        if (ack && m_ready) begin
            m_ready = 1'b0;
            m_err   = 1'b0;
        end
        if (!stop_ok) begin
            m_err = 1'b1;
        end else if (!m_ready) begin
            m_data  = d;
            m_ready = 1'b1;
            if (PAR_EN && !par_ok) m_err = 1'b1;
        end else begin
            m_err = 1'b1;
        end
        model_push();
        // A stop bit held low re-arms the receiver, which then rejects it as a glitch.
        if (!stop_ok) model_push();
    endfunction

    // Monitor: one check per frame end (busy falling) or ack, taken one edge later for frames.
    initial begin
        logic bprev;
        logic pend;
        exp_t e;
        bprev = 1'b0;
        pend  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                pend  = 1'b0;
                bprev = 1'b0;
            end else begin
                if (pend || rd_ack_i) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event: data=%h status=%b with no expected entry",
                                 rx_data_o, status_o);
                    end else begin
                        e = exp_q.pop_front();
                        if (rx_data_o !== e.data || status_o !== e.status) begin
                            errors++;
                            $display("FAIL scoreboard: data=%h status=%b, expected data=%h status=%b",
                                     rx_data_o, status_o, e.data, e.status);
                        end
                    end
                end
                pend  = bprev && !busy_o;
                bprev = busy_o;
            end
        end
    end

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic ack();
        if (m_ready) begin
            m_ready = 1'b0;
            m_err   = 1'b0;
        end
        model_push();
        @(negedge clk);
        rd_ack_i = 1'b1;
        @(negedge clk);
        rd_ack_i = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok,
                              input logic par_ok, input logic ack_done);
        logic bp;
        logic acked;
        int   len;
        model_frame(d, stop_ok, par_ok, ack_done);
        rx_i = 1'b0;
        repeat (T) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            repeat (T) @(negedge clk);
        end
        if (PAR_EN) begin
            rx_i = (^d) ^ !par_ok;
            repeat (T) @(negedge clk);
        end
        rx_i  = stop_ok;
        len   = stop_ok ? T : T / 2 + 8;
        bp    = busy_o;
        acked = 1'b0;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            rd_ack_i = 1'b0;
            if (ack_done && !acked && bp && !busy_o) begin
                rd_ack_i = 1'b1;
                acked    = 1'b1;
            end
            bp = busy_o;
        end
        if (rd_ack_i) begin
            @(negedge clk);
            rd_ack_i = 1'b0;
        end
        if (ack_done) chk("ack_at_completion_found", {31'b0, acked}, 32'd1);
        if (!stop_ok) idle(2 * T);
    endtask

    task automatic glitch();
        model_push();
        rx_i = 1'b0;
        repeat (T / 4) @(negedge clk);
        idle(2 * T);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic       s_ok, p_ok, a_done;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_data", {24'b0, rx_data_o}, 32'h0);
        chk("reset_status", {30'b0, status_o}, 32'h0);
        chk("reset_busy", {31'b0, busy_o}, 32'h0);
        reset_n = 1'b1;
        idle(T);

        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        idle(T);
        ack();

        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b1, 1'b0);
        idle(T);
        ack();

        send_frame(8'h55, 1'b0, 1'b1, 1'b0);
        ack();
        glitch();

        send_frame(8'h7E, 1'b1, 1'b1, 1'b0);
        ack();

        send_frame(8'h18, 1'b1, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 1'b1, 1'b1);
        idle(T);
        ack();

        if (PAR_EN) begin
            send_frame(8'h07, 1'b1, 1'b0, 1'b0);
            ack();
        end

        // Leave ready set, then reset in the middle of a frame.
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        rx_i = 1'b0;
        repeat (3 * T) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset_data", {24'b0, rx_data_o}, 32'h0);
        chk("midreset_status", {30'b0, status_o}, 32'h0);
        chk("midreset_busy", {31'b0, busy_o}, 32'h0);
        repeat (2) @(negedge clk);
        rx_i    = 1'b1;
        reset_n = 1'b1;
        model_reset();
        idle(2 * T);
        send_frame(8'h96, 1'b1, 1'b1, 1'b0);
        idle(T);
        ack();

        for (int n = 0; n < 25; n++) begin
            d      = 8'($urandom);
            s_ok   = ($urandom_range(0, 5) != 0);
            p_ok   = !PAR_EN || ($urandom_range(0, 5) != 0);
            a_done = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) ack();
            send_frame(d, s_ok, p_ok, a_done);
            if ($urandom_range(0, 2) == 0) idle(T / 2);
        end

        idle(2 * T);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
